// File: rtl/nanorv32_trace_ascii.sv
// Trace helper: RV32 instruction word -> 8-char ASCII mnemonic, register indices -> ABI names.
// Optional RV32M mnemonics enabled by defining NANORV32_ASCII_RVM_EN.
module nanorv32_trace_ascii #(
    parameter logic [7:0] PAD_CHAR = 8'h20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_in,
    input  logic [31:0] instruction_r,
    input  logic [4:0]  reg_rd,
    input  logic [4:0]  reg_rd2,
    input  logic [4:0]  reg_rs1,
    input  logic [4:0]  reg_rs2,
    output logic        valid_out,
    output logic [63:0] ascii_chain,
    output logic [31:0] reg_to_ascii_rd,
    output logic [31:0] reg_to_ascii_rd2,
    output logic [31:0] reg_to_ascii_rs1,
    output logic [31:0] reg_to_ascii_rs2
);

    localparam int unsigned MNEM_CHARS = 8;
    localparam int unsigned REG_CHARS  = 4;
    localparam int unsigned MNEM_W     = 8 * MNEM_CHARS;
    localparam int unsigned REG_W      = 8 * REG_CHARS;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
`ifdef NANORV32_ASCII_RVM_EN
    localparam logic [6:0] F7_MULDIV = 7'b0000001;
`endif

    // Names are built as right-justified zero-filled literals; move them left and pad the tail.
    function automatic logic [MNEM_W-1:0] justify_mnem(input logic [MNEM_W-1:0] s);
        logic [MNEM_W-1:0] r;
        int unsigned       n;
        n = 0;
        for (int unsigned i = 0; i < MNEM_CHARS; i++) begin
            if (s[8*i +: 8] != 8'h00) n = i + 1;
        end
        r = s << (8 * (MNEM_CHARS - n));
        for (int unsigned i = 0; i < MNEM_CHARS; i++) begin
            if (i < MNEM_CHARS - n) r[8*i +: 8] = PAD_CHAR;
        end
        return r;
    endfunction

    function automatic logic [REG_W-1:0] justify_reg(input logic [REG_W-1:0] s);
        logic [REG_W-1:0] r;
        int unsigned      n;
        n = 0;
        for (int unsigned i = 0; i < REG_CHARS; i++) begin
            if (s[8*i +: 8] != 8'h00) n = i + 1;
        end
        r = s << (8 * (REG_CHARS - n));
        for (int unsigned i = 0; i < REG_CHARS; i++) begin
            if (i < REG_CHARS - n) r[8*i +: 8] = PAD_CHAR;
        end
        return r;
    endfunction

    // ABI register name lookup, shared by all four converters.
    function automatic logic [REG_W-1:0] reg_name(input logic [4:0] idx);
        logic [REG_W-1:0] s;
        s = 32'("zero");
        case (idx)
            5'd0:  s = 32'("zero");
            5'd1:  s = 32'("ra");
            5'd2:  s = 32'("sp");
            5'd3:  s = 32'("gp");
            5'd4:  s = 32'("tp");
            5'd5:  s = 32'("t0");
            5'd6:  s = 32'("t1");
            5'd7:  s = 32'("t2");
            5'd8:  s = 32'("s0");
            5'd9:  s = 32'("s1");
            5'd10: s = 32'("a0");
            5'd11: s = 32'("a1");
            5'd12: s = 32'("a2");
            5'd13: s = 32'("a3");
            5'd14: s = 32'("a4");
            5'd15: s = 32'("a5");
            5'd16: s = 32'("a6");
            5'd17: s = 32'("a7");
            5'd18: s = 32'("s2");
            5'd19: s = 32'("s3");
            5'd20: s = 32'("s4");
            5'd21: s = 32'("s5");
            5'd22: s = 32'("s6");
            5'd23: s = 32'("s7");
            5'd24: s = 32'("s8");
            5'd25: s = 32'("s9");
            5'd26: s = 32'("s10");
            5'd27: s = 32'("s11");
            5'd28: s = 32'("t3");
            5'd29: s = 32'("t4");
            5'd30: s = 32'("t5");
            5'd31: s = 32'("t6");
            default: s = 32'("zero");
        endcase
        return justify_reg(s);
    endfunction

    logic [6:0]        opcode;
    logic [2:0]        funct3;
    logic [6:0]        funct7;
    logic [11:0]       sys_imm;
    logic [MNEM_W-1:0] mnem_raw;
    logic [MNEM_W-1:0] mnem_c;

    assign opcode  = instruction_r[6:0];
    assign funct3  = instruction_r[14:12];
    assign funct7  = instruction_r[31:25];
    assign sys_imm = instruction_r[31:20];

    // Mnemonic decode; anything not matched below stays "illegal".
    always_comb begin
        mnem_raw = 64'("illegal");
        if (instruction_r[1:0] == 2'b11) begin
            case (opcode)
                OP_LUI:   mnem_raw = 64'("lui");
                OP_AUIPC: mnem_raw = 64'("auipc");
                OP_JAL:   mnem_raw = 64'("jal");
                OP_JALR:  if (funct3 == 3'b000) mnem_raw = 64'("jalr");
                OP_BRANCH: begin
                    case (funct3)
                        3'b000:  mnem_raw = 64'("beq");
                        3'b001:  mnem_raw = 64'("bne");
                        3'b100:  mnem_raw = 64'("blt");
                        3'b101:  mnem_raw = 64'("bge");
                        3'b110:  mnem_raw = 64'("bltu");
                        3'b111:  mnem_raw = 64'("bgeu");
                        default: ;
                    endcase
                end
                OP_LOAD: begin
                    case (funct3)
                        3'b000:  mnem_raw = 64'("lb");
                        3'b001:  mnem_raw = 64'("lh");
                        3'b010:  mnem_raw = 64'("lw");
                        3'b100:  mnem_raw = 64'("lbu");
                        3'b101:  mnem_raw = 64'("lhu");
                        default: ;
                    endcase
                end
                OP_STORE: begin
                    case (funct3)
                        3'b000:  mnem_raw = 64'("sb");
                        3'b001:  mnem_raw = 64'("sh");
                        3'b010:  mnem_raw = 64'("sw");
                        default: ;
                    endcase
                end
                OP_IMM: begin
                    case (funct3)
                        3'b000: mnem_raw = 64'("addi");
                        3'b010: mnem_raw = 64'("slti");
                        3'b011: mnem_raw = 64'("sltiu");
                        3'b100: mnem_raw = 64'("xori");
                        3'b110: mnem_raw = 64'("ori");
                        3'b111: mnem_raw = 64'("andi");
                        3'b001: if (funct7 == F7_BASE) mnem_raw = 64'("slli");
                        3'b101: begin
                            if (funct7 == F7_BASE)     mnem_raw = 64'("srli");
                            else if (funct7 == F7_ALT) mnem_raw = 64'("srai");
                        end
                        default: ;
                    endcase
                end
                OP_REG: begin
                    if (funct7 == F7_BASE) begin
                        case (funct3)
                            3'b000:  mnem_raw = 64'("add");
                            3'b001:  mnem_raw = 64'("sll");
                            3'b010:  mnem_raw = 64'("slt");
                            3'b011:  mnem_raw = 64'("sltu");
                            3'b100:  mnem_raw = 64'("xor");
                            3'b101:  mnem_raw = 64'("srl");
                            3'b110:  mnem_raw = 64'("or");
                            3'b111:  mnem_raw = 64'("and");
                            default: ;
                        endcase
                    end else if (funct7 == F7_ALT) begin
                        if (funct3 == 3'b000)      mnem_raw = 64'("sub");
                        else if (funct3 == 3'b101) mnem_raw = 64'("sra");
`ifdef NANORV32_ASCII_RVM_EN
                    end else if (funct7 == F7_MULDIV) begin
                        case (funct3)
                            3'b000:  mnem_raw = 64'("mul");
                            3'b001:  mnem_raw = 64'("mulh");
                            3'b010:  mnem_raw = 64'("mulhsu");
                            3'b011:  mnem_raw = 64'("mulhu");
                            3'b100:  mnem_raw = 64'("div");
                            3'b101:  mnem_raw = 64'("divu");
                            3'b110:  mnem_raw = 64'("rem");
                            3'b111:  mnem_raw = 64'("remu");
                            default: ;
                        endcase
`else
                    end else begin
                        mnem_raw = 64'("illegal");
`endif
                    end
                end
                OP_FENCE: begin
                    if (funct3 == 3'b000)      mnem_raw = 64'("fence");
                    else if (funct3 == 3'b001) mnem_raw = 64'("fence.i");
                end
                OP_SYSTEM: begin
                    case (funct3)
                        3'b000: begin
                            case (sys_imm)
                                12'h000: mnem_raw = 64'("ecall");
                                12'h001: mnem_raw = 64'("ebreak");
                                12'h302: mnem_raw = 64'("mret");
                                12'h105: mnem_raw = 64'("wfi");
                                default: ;
                            endcase
                        end
                        3'b001:  mnem_raw = 64'("csrrw");
                        3'b010:  mnem_raw = 64'("csrrs");
                        3'b011:  mnem_raw = 64'("csrrc");
                        3'b101:  mnem_raw = 64'("csrrwi");
                        3'b110:  mnem_raw = 64'("csrrsi");
                        3'b111:  mnem_raw = 64'("csrrci");
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
        mnem_c = justify_mnem(mnem_raw);
    end

    // Output registers: load on valid_in, hold otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_out        <= 1'b0;
            ascii_chain      <= {MNEM_CHARS{PAD_CHAR}};
            reg_to_ascii_rd  <= {REG_CHARS{PAD_CHAR}};
            reg_to_ascii_rd2 <= {REG_CHARS{PAD_CHAR}};
            reg_to_ascii_rs1 <= {REG_CHARS{PAD_CHAR}};
            reg_to_ascii_rs2 <= {REG_CHARS{PAD_CHAR}};
        end else begin
            valid_out <= valid_in;
            if (valid_in) begin
                ascii_chain      <= mnem_c;
                reg_to_ascii_rd  <= reg_name(reg_rd);
                reg_to_ascii_rd2 <= reg_name(reg_rd2);
                reg_to_ascii_rs1 <= reg_name(reg_rs1);
                reg_to_ascii_rs2 <= reg_name(reg_rs2);
            end
        end
    end

endmodule

// File: tb/tb_nanorv32_trace_ascii.sv
// Bench for nanorv32_trace_ascii: directed vectors plus random instructions against a
// string-table reference model. Honours NANORV32_ASCII_RVM_EN like the design.
module tb_nanorv32_trace_ascii;

    logic        clk;
    logic        rst;
    logic        valid_in;
    logic [31:0] instruction_r;
    logic [4:0]  reg_rd, reg_rd2, reg_rs1, reg_rs2;
    logic        valid_out;
    logic [63:0] ascii_chain;
    logic [31:0] reg_to_ascii_rd, reg_to_ascii_rd2, reg_to_ascii_rs1, reg_to_ascii_rs2;

    int n_cmp = 0;
    int n_err = 0;

    logic [63:0] exp_chain;
    logic [31:0] exp_rd, exp_rd2, exp_rs1, exp_rs2;
    logic        exp_valid;

    nanorv32_trace_ascii dut (
        .clk              (clk),
        .rst              (rst),
        .valid_in         (valid_in),
        .instruction_r    (instruction_r),
        .reg_rd           (reg_rd),
        .reg_rd2          (reg_rd2),
        .reg_rs1          (reg_rs1),
        .reg_rs2          (reg_rs2),
        .valid_out        (valid_out),
        .ascii_chain      (ascii_chain),
        .reg_to_ascii_rd  (reg_to_ascii_rd),
        .reg_to_ascii_rd2 (reg_to_ascii_rd2),
        .reg_to_ascii_rs1 (reg_to_ascii_rs1),
        .reg_to_ascii_rs2 (reg_to_ascii_rs2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference tables; an empty string marks an encoding with no mnemonic.
    string reg_names [32] = '{"zero", "ra", "sp", "gp", "tp", "t0", "t1", "t2",
                              "s0", "s1", "a0", "a1", "a2", "a3", "a4", "a5",
                              "a6", "a7", "s2", "s3", "s4", "s5", "s6", "s7",
                              "s8", "s9", "s10", "s11", "t3", "t4", "t5", "t6"};
    string br_t  [8] = '{"beq", "bne", "", "", "blt", "bge", "bltu", "bgeu"};
    string ld_t  [8] = '{"lb", "lh", "lw", "", "lbu", "lhu", "", ""};
    string st_t  [8] = '{"sb", "sh", "sw", "", "", "", "", ""};
    string opi_t [8] = '{"addi", "", "slti", "sltiu", "xori", "", "ori", "andi"};
    string op_t  [8] = '{"add", "sll", "slt", "sltu", "xor", "srl", "or", "and"};
    string mul_t [8] = '{"mul", "mulh", "mulhsu", "mulhu", "div", "divu", "rem", "remu"};
    string csr_t [8] = '{"", "csrrw", "csrrs", "csrrc", "", "csrrwi", "csrrsi", "csrrci"};
    logic [6:0]  opc_t [11] = '{7'h37, 7'h17, 7'h6f, 7'h67, 7'h63, 7'h03, 7'h23,
                                7'h13, 7'h33, 7'h0f, 7'h73};
    logic [11:0] sysi_t [4] = '{12'h000, 12'h001, 12'h302, 12'h105};

    function automatic string ref_mnem(input logic [31:0] w);
        string       m;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [11:0] imm;
        f3  = w[14:12];
        f7  = w[31:25];
        imm = w[31:20];
        m   = "";
        if (w[1:0] == 2'b11) begin
            case (w[6:0])
                7'h37: m = "lui";
                7'h17: m = "auipc";
                7'h6f: m = "jal";
                7'h67: m = (f3 == 3'd0) ? "jalr" : "";
                7'h63: m = br_t[f3];
                7'h03: m = ld_t[f3];
                7'h23: m = st_t[f3];
                7'h13: begin
                    if (f3 == 3'd1)      m = (f7 == 7'h00) ? "slli" : "";
                    else if (f3 == 3'd5) m = (f7 == 7'h00) ? "srli" : (f7 == 7'h20) ? "srai" : "";
                    else                 m = opi_t[f3];
                end
                7'h33: begin
                    if (f7 == 7'h00)      m = op_t[f3];
                    else if (f7 == 7'h20) m = (f3 == 3'd0) ? "sub" : (f3 == 3'd5) ? "sra" : "";
`ifdef NANORV32_ASCII_RVM_EN
                    else if (f7 == 7'h01) m = mul_t[f3];
`endif
                end
                7'h0f: m = (f3 == 3'd0) ? "fence" : (f3 == 3'd1) ? "fence.i" : "";
                7'h73: begin
                    if (f3 != 3'd0)         m = csr_t[f3];
                    else if (imm == 12'h000) m = "ecall";
                    else if (imm == 12'h001) m = "ebreak";
                    else if (imm == 12'h302) m = "mret";
                    else if (imm == 12'h105) m = "wfi";
                end
                default: m = "";
            endcase
        end
        if (m.len() == 0) m = "illegal";
        return m;
    endfunction

    // Left-justified, space-padded ASCII image of s in n bytes.
    function automatic logic [63:0] s2b(input string s, input int n);
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < n; i++)
            r[8*(n-1-i) +: 8] = (i < s.len()) ? s[i] : 8'h20;
        return r;
    endfunction

    function automatic logic [31:0] rand_insn();
        logic [31:0] w;
        int unsigned sel;
        w   = $urandom;
        sel = $urandom_range(0, 11);
        if (sel < 11) w[6:0] = opc_t[sel];
        case ($urandom_range(0, 3))
            0: w[31:25] = 7'h00;
            1: w[31:25] = 7'h20;
            2: w[31:25] = 7'h01;
            default: ;
        endcase
        if (w[6:0] == 7'h73 && $urandom_range(0, 1) == 1) begin
            w[31:20] = sysi_t[$urandom_range(0, 3)];
            w[14:12] = 3'd0;
        end
        return w;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".valid"}, 64'(valid_out), 64'(exp_valid));
        check({tag, ".mnem"}, ascii_chain, exp_chain);
        check({tag, ".rd"}, 64'(reg_to_ascii_rd), 64'(exp_rd));
        check({tag, ".rd2"}, 64'(reg_to_ascii_rd2), 64'(exp_rd2));
        check({tag, ".rs1"}, 64'(reg_to_ascii_rs1), 64'(exp_rs1));
        check({tag, ".rs2"}, 64'(reg_to_ascii_rs2), 64'(exp_rs2));
    endtask

    task automatic set_exp_reset();
        exp_valid = 1'b0;
        exp_chain = 64'h2020202020202020;
        exp_rd    = 32'h20202020;
        exp_rd2   = 32'h20202020;
        exp_rs1   = 32'h20202020;
        exp_rs2   = 32'h20202020;
    endtask

    // Drive one cycle of inputs, update the model, then compare after the edge.
    task automatic apply(input string tag, input logic [31:0] ins, input logic [4:0] rd,
                         input logic [4:0] rd2, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic v);
        @(negedge clk);
        valid_in      = v;
        instruction_r = ins;
        reg_rd        = rd;
        reg_rd2       = rd2;
        reg_rs1       = rs1;
        reg_rs2       = rs2;
        @(posedge clk);
        #1;
        exp_valid = v;
        if (v) begin
            exp_chain = s2b(ref_mnem(ins), 8);
            exp_rd    = s2b(reg_names[rd], 4)[31:0];
            exp_rd2   = s2b(reg_names[rd2], 4)[31:0];
            exp_rs1   = s2b(reg_names[rs1], 4)[31:0];
            exp_rs2   = s2b(reg_names[rs2], 4)[31:0];
        end
        check_all(tag);
    endtask

    initial begin
        rst = 1'b1;
        valid_in = 1'b0;
        instruction_r = '0;
        reg_rd = '0; reg_rd2 = '0; reg_rs1 = '0; reg_rs2 = '0;
        set_exp_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        @(negedge clk);
        rst = 1'b0;

        apply("addi", 32'h00A00513, 5'd10, 5'd0, 5'd0, 5'd27, 1'b1);
        check("addi_lit", ascii_chain, 64'h6164646920202020);
        check("a0_lit", 64'(reg_to_ascii_rd), 64'(32'h61302020));
        check("zero_lit", 64'(reg_to_ascii_rs1), 64'(32'h7A65726F));
        check("s11_lit", 64'(reg_to_ascii_rs2), 64'(32'h73313120));

        apply("hold", 32'h40B50533, 5'd1, 5'd2, 5'd3, 5'd4, 1'b0);
        check("hold_lit", ascii_chain, 64'h6164646920202020);

        apply("sub", 32'h40B50533, 5'd31, 5'd28, 5'd18, 5'd8, 1'b1);
        check("sub_lit", ascii_chain, 64'h7375622020202020);
        apply("fencei", 32'h0000100F, 5'd5, 5'd6, 5'd7, 5'd9, 1'b1);
        check("fencei_lit", ascii_chain, 64'h66656E63652E6920);
        apply("ill_ff", 32'hFFFFFFFF, 5'd11, 5'd12, 5'd13, 5'd14, 1'b1);
        check("ill_ff_lit", ascii_chain, 64'h696C6C6567616C20);
        apply("ill_01", 32'h00000001, 5'd15, 5'd16, 5'd17, 5'd19, 1'b1);
        check("ill_01_lit", ascii_chain, 64'h696C6C6567616C20);
        apply("mul", 32'h02B50533, 5'd20, 5'd21, 5'd22, 5'd23, 1'b1);
`ifdef NANORV32_ASCII_RVM_EN
        check("mul_lit", ascii_chain, 64'h6D756C2020202020);
`else
        check("mul_lit", ascii_chain, 64'h696C6C6567616C20);
`endif
        apply("mret", 32'h30200073, 5'd24, 5'd25, 5'd26, 5'd29, 1'b1);
        apply("slli_bad", 32'h40051513, 5'd30, 5'd1, 5'd2, 5'd3, 1'b1);

        for (int i = 0; i < 400; i++) begin
            apply("rand", rand_insn(), 5'($urandom), 5'($urandom), 5'($urandom),
                  5'($urandom), ($urandom_range(0, 3) != 0));
        end

        // Asynchronous reset between clock edges.
        apply("pre_rst", 32'h00A00513, 5'd10, 5'd11, 5'd12, 5'd13, 1'b1);
        @(negedge clk);
        valid_in = 1'b0;
        #2 rst = 1'b1;
        #1;
        set_exp_reset();
        check_all("async_rst");
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
        check_all("post_rst");
        apply("after", 32'h0000006F, 5'd1, 5'd2, 5'd3, 5'd4, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
